// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one serial multiplier controller between two
// requesters, with a watchdog that aborts a transaction whose done never arrives.
`timescale 1ns/1ps
module mult_arbiter #(
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 128,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [IDX_W-1:0] srcA0,
  input  logic [IDX_W-1:0] srcB0,
  input  logic [IDX_W-1:0] dst0,
  input  logic [IDX_W-1:0] srcA1,
  input  logic [IDX_W-1:0] srcB1,
  input  logic [IDX_W-1:0] dst1,
  input  logic             lr0,
  input  logic             lr1,
  input  logic             done,
  output logic             start,
  output logic [IDX_W-1:0] cfg_srcA,
  output logic [IDX_W-1:0] cfg_srcB,
  output logic [IDX_W-1:0] cfg_dst,
  output logic             cfg_lr,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       ack,
  output logic             err,
  output logic             err_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_ACK,
    S_ERR
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_d;
  logic             last_gnt;
  logic             last_gnt_d;

  logic             win;
  logic             cur;
  logic             wd_expired;
  logic             grant_now;

  logic             start_d;
  logic [1:0]       gnt_d;
  logic [1:0]       ack_d;
  logic             err_d;
  logic             err_id_d;
  logic             busy_d;
  logic [IDX_W-1:0] cfg_srcA_d;
  logic [IDX_W-1:0] cfg_srcB_d;
  logic [IDX_W-1:0] cfg_dst_d;
  logic             cfg_lr_d;

  // On a tie the requester that did not win last time goes next.
  assign win        = (req == 2'b11) ? ~last_gnt : req[1];
  assign cur        = gnt[1];
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign grant_now  = (state == S_IDLE) && (next_state == S_ISSUE);

  // State and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      last_gnt <= 1'b1;
      start    <= 1'b0;
      gnt      <= 2'b00;
      ack      <= 2'b00;
      err      <= 1'b0;
      err_id   <= 1'b0;
      busy     <= 1'b0;
      cfg_srcA <= '0;
      cfg_srcB <= '0;
      cfg_dst  <= '0;
      cfg_lr   <= 1'b0;
    end else begin
      state    <= next_state;
      wd_cnt   <= wd_cnt_d;
      last_gnt <= last_gnt_d;
      start    <= start_d;
      gnt      <= gnt_d;
      ack      <= ack_d;
      err      <= err_d;
      err_id   <= err_id_d;
      busy     <= busy_d;
      cfg_srcA <= cfg_srcA_d;
      cfg_srcB <= cfg_srcB_d;
      cfg_dst  <= cfg_dst_d;
      cfg_lr   <= cfg_lr_d;
    end
  end

  // A done still high from the previous job must not launch a new one.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    next_state = state;
    unique case (state)
      S_IDLE:  if (|req && !done) next_state = S_ISSUE;
      S_ISSUE: next_state = S_BUSY;
      S_BUSY: begin
        if (done)            next_state = S_ACK;
        else if (wd_expired) next_state = S_ERR;
      end
      S_ACK:   next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start_d    = (next_state == S_ISSUE);
    busy_d     = (next_state != S_IDLE);
    ack_d      = (next_state == S_ACK) ? gnt : 2'b00;
    err_d      = (next_state == S_ERR);
    err_id_d   = (next_state == S_ERR) ? cur : 1'b0;
    wd_cnt_d   = (state == S_BUSY && next_state == S_BUSY) ? wd_cnt + CNT_W'(1) : '0;
    last_gnt_d = (state == S_ACK || state == S_ERR) ? cur : last_gnt;
    gnt_d      = gnt;
    cfg_srcA_d = cfg_srcA;
    cfg_srcB_d = cfg_srcB;
    cfg_dst_d  = cfg_dst;
    cfg_lr_d   = cfg_lr;
    if (grant_now) begin
      gnt_d      = {win, ~win};
      cfg_srcA_d = win ? srcA1 : srcA0;
      cfg_srcB_d = win ? srcB1 : srcB0;
      cfg_dst_d  = win ? dst1  : dst0;
      cfg_lr_d   = win ? lr1   : lr0;
    end else if (next_state == S_IDLE) begin
      gnt_d = 2'b00;
    end
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares the single serial multiplier controller (start/done sequencer plus its register-file datapath) between two requesters.
- Accepts per-requester operand/destination register indices and shift direction, then grants round-robin.
- Latches the winner's configuration, pulses start, waits for done, and returns ack to the winner.
- Watchdog aborts with err if done never arrives; sits directly above the multiplier FSM in the datapath hierarchy.

Parameters:
IDX_W, 3, width of register index fields (selects one of 5 registers, values 0..4 legal)
TIMEOUT, 128, maximum BUSY cycles allowed before abort
CNT_W, 8, watchdog counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  2  request per requester; hold high with its fields stable until ack or err for it
srcA0, srcB0, dst0  input  IDX_W each  requester 0 register indices
srcA1, srcB1, dst1  input  IDX_W each  requester 1 register indices
lr0, lr1  input  1 each  shift direction per requester
done  input  1  multiplier FSM complete, level or pulse
start  output  1  one-cycle start pulse to multiplier FSM
cfg_srcA, cfg_srcB, cfg_dst  output  IDX_W each  latched indices of granted requester
cfg_lr  output  1  latched shift direction of granted requester
gnt  output  2  one-hot grant, held ISSUE through ACK/ERR
busy  output  1  high in any state except IDLE
ack  output  2  one-cycle completion pulse to granted requester
err  output  1  one-cycle watchdog abort pulse
err_id  output  1  requester that was aborted, valid while err=1

Behaviour:
- All outputs registered. Reset (asynchronous, immediate) forces: state IDLE, start=0, gnt=0, ack=0, err=0, err_id=0, busy=0, all cfg_*=0, watchdog=0, last-grant pointer=1 (requester 0 wins the first tie). Reset mid-transaction abandons it silently, with no ack or err.
- States:
  - IDLE -> ISSUE when |req and done==0. While done is high, remain in IDLE (a stale done must not be reused).
  - ISSUE (1 cycle): start=1, gnt set, cfg_* hold latched values. -> BUSY.
  - BUSY: watchdog increments each cycle.
    - done==1 -> ACK. Done takes priority if it arrives on the same cycle the watchdog expires.
    - Watchdog reaches TIMEOUT-1 with done==0 -> ERR.
  - ACK (1 cycle): ack[g]=1. -> IDLE.
  - ERR (1 cycle): err=1, err_id=g. -> IDLE.
- Arbitration, on the IDLE->ISSUE edge:
  - Single request: it wins.
  - Both requesting: winner is the requester other than the last-grant pointer.
  - Pointer updates to the winner on exit from ACK or ERR.
- cfg_* and gnt latched on the IDLE->ISSUE edge. Input changes afterward are ignored. cfg_* retain values in IDLE; gnt clears in IDLE.
- Dropping req after grant does not cancel the transaction.
- Latency:
  - req high at edge k (IDLE, done low) -> start visible cycle k+1.
  - done sampled at edge m -> ack visible cycle m+1.
  - Earliest next start: 2 cycles after ack (one IDLE cycle).
- Watchdog clears on entry to ISSUE. Exactly TIMEOUT BUSY cycles elapse before ERR.
- Index values 5..7 are passed through unchecked (checking is the downstream FSM's job).

Test Plan:
- Reset then req=01, srcA0=1, srcB0=2, dst0=3, lr0=1; done pulses 20 cycles after start -> one start pulse, cfg=1/2/3/1, gnt=01 through ACK, ack=01 exactly one cycle, busy drops after ACK.
- req=11 held continuously, done returned 10 cycles after each start -> grants alternate 01,10,01,10, with one IDLE cycle between ack and next start.
- req=01 with done tied low -> err=1, err_id=0 exactly 128 BUSY cycles after start, no ack, FSM back to IDLE; next req=11 grants requester 1.
- done already high in IDLE with req=10 -> no start until done falls; start follows the cycle after.
- Assert rst 5 cycles into BUSY -> all outputs 0 immediately (asynchronous), no ack or err; after release req=11 grants requester 0.
- During BUSY, change srcA0 and drop req[0] -> cfg_srcA unchanged, transaction completes with ack=01 when done arrives.
